// File: rtl/jtdd_adpcm_seq.sv
// N-channel ADPCM sample sequencer: walks each channel's ROM page range and
// emits one 4-bit code per sample strobe, high nibble first.
module jtdd_adpcm_seq #(
  parameter int CH     = 2,
  parameter int AW     = 17,
  parameter int IRQ_EN = 1
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen_smp,
  input  logic            cpu_wr,
  input  logic [5:0]      cpu_addr,
  input  logic [7:0]      cpu_din,
  output logic [7:0]      cpu_dout,
  output logic [CH*AW-1:0] rom_addr,
  output logic [CH-1:0]   rom_cs,
  input  logic [8*CH-1:0] rom_data,
  input  logic [CH-1:0]   rom_ok,
  output logic [4*CH-1:0] nib,
  output logic [CH-1:0]   nib_stb,
  output logic [CH-1:0]   dec_rst,
  output logic [CH-1:0]   busy,
  output logic            irq
);

  localparam int PW = AW - 8;
  localparam logic [7:0] HI_MASK = 8'((32'd1 << (PW - 8)) - 32'd1);

  logic [2:0]   cpu_ch, cpu_reg;
  logic [127:0] start8, end8;
  logic [7:0]   busy8, done8, under8;

  assign cpu_ch  = cpu_addr[5:3];
  assign cpu_reg = cpu_addr[2:0];

  for (genvar k = 0; k < CH; k++) begin : g_ch
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, PLAY = 2'd2} state_t;
    state_t        st;
    logic [15:0]   start_pg, end_pg;
    logic [AW-1:0] addr, start_addr, end_addr;
    logic [7:0]    dbuf;
    logic [3:0]    nib_r;
    logic          hi, stable, done, under, stb, rst_pulse;
    logic          wr_ch, wr_ctl, done_now, under_now;

    assign wr_ch      = cpu_wr && (int'(cpu_ch) == k);
    assign wr_ctl     = wr_ch && (cpu_reg == 3'd4);
    assign start_addr = {start_pg[PW-1:0], 8'h00};
    assign end_addr   = {end_pg[PW-1:0], 8'hFF};
    assign done_now   = (st == PLAY) && cen_smp && !hi && (addr == end_addr);
    assign under_now  = (st == FETCH) && cen_smp;

    // Control writes are applied last so start/stop override the playback
    // step, while done/underrun sets still beat a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st        <= IDLE;
        start_pg  <= '0;
        end_pg    <= '0;
        addr      <= '0;
        dbuf      <= '0;
        nib_r     <= '0;
        hi        <= 1'b0;
        stable    <= 1'b0;
        done      <= 1'b0;
        under     <= 1'b0;
        stb       <= 1'b0;
        rst_pulse <= 1'b0;
      end else begin
        stb       <= 1'b0;
        rst_pulse <= 1'b0;
        if (wr_ch) begin
          case (cpu_reg)
            3'd0:    start_pg[7:0]  <= cpu_din;
            3'd1:    start_pg[15:8] <= cpu_din & HI_MASK;
            3'd2:    end_pg[7:0]    <= cpu_din;
            3'd3:    end_pg[15:8]   <= cpu_din & HI_MASK;
            default: ;
          endcase
        end
        if (wr_ctl && cpu_din[7]) begin
          done  <= 1'b0;
          under <= 1'b0;
        end
        if (done_now)  done  <= 1'b1;
        if (under_now) under <= 1'b1;

        case (st)
          IDLE: ;
          // ok is trusted only once the address has been stable a full cycle
          FETCH: begin
            stable <= 1'b1;
            if (stable && rom_ok[k]) begin
              dbuf <= rom_data[k*8 +: 8];
              st   <= PLAY;
            end
          end
          PLAY: begin
            if (cen_smp) begin
              stb <= 1'b1;
              if (hi) begin
                nib_r <= dbuf[7:4];
                hi    <= 1'b0;
              end else begin
                nib_r <= dbuf[3:0];
                hi    <= 1'b1;
                if (addr == end_addr) begin
                  st <= IDLE;
                end else begin
                  addr   <= addr + 1'b1;
                  stable <= 1'b0;
                  st     <= FETCH;
                end
              end
            end
          end
          default: st <= IDLE;
        endcase

        if (wr_ctl) begin
          if (cpu_din[0]) begin
            addr      <= start_addr;
            hi        <= 1'b1;
            stable    <= 1'b0;
            st        <= FETCH;
            rst_pulse <= (st != IDLE);
          end else begin
            st <= IDLE;
          end
        end
      end
    end

    assign rom_addr[k*AW +: AW] = addr;
    assign rom_cs[k]            = (st == FETCH);
    assign busy[k]              = (st != IDLE);
    assign dec_rst[k]           = (st == IDLE) || rst_pulse;
    assign nib[k*4 +: 4]        = nib_r;
    assign nib_stb[k]           = stb;
    assign start8[k*16 +: 16]   = start_pg;
    assign end8[k*16 +: 16]     = end_pg;
    assign busy8[k]             = (st != IDLE);
    assign done8[k]             = done;
    assign under8[k]            = under;
  end

  for (genvar k = CH; k < 8; k++) begin : g_pad
    assign start8[k*16 +: 16] = '0;
    assign end8[k*16 +: 16]   = '0;
    assign busy8[k]           = 1'b0;
    assign done8[k]           = 1'b0;
    assign under8[k]          = 1'b0;
  end

  always_comb begin
    cpu_dout = 8'hFF;
    if (int'(cpu_ch) < CH) begin
      case (cpu_reg)
        3'd0:    cpu_dout = start8[{cpu_ch, 4'd0} +: 8];
        3'd1:    cpu_dout = start8[{cpu_ch, 4'd8} +: 8];
        3'd2:    cpu_dout = end8[{cpu_ch, 4'd0} +: 8];
        3'd3:    cpu_dout = end8[{cpu_ch, 4'd8} +: 8];
        3'd4:    cpu_dout = {7'd0, busy8[cpu_ch]};
        3'd5:    cpu_dout = {5'd0, under8[cpu_ch], done8[cpu_ch], busy8[cpu_ch]};
        default: cpu_dout = 8'hFF;
      endcase
    end
  end

  if (IRQ_EN != 0) begin : g_irq
    assign irq = |done8;
  end else begin : g_noirq
    assign irq = 1'b0;
  end

endmodule

// File: tb/tb_jtdd_adpcm_seq.sv
// Bench for jtdd_adpcm_seq: ROM responders, sample strobe generator and a
// nibble/address scoreboard built from the page ranges each channel is given.
module tb_jtdd_adpcm_seq;
  localparam int CH = 2;
  localparam int AW = 17;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            cen_smp = 1'b0;
  logic            cpu_wr = 1'b0;
  logic [5:0]      cpu_addr = '0;
  logic [7:0]      cpu_din = '0;
  logic [7:0]      cpu_dout;
  logic [CH*AW-1:0] rom_addr;
  logic [CH-1:0]   rom_cs;
  logic [8*CH-1:0] rom_data;
  logic [CH-1:0]   rom_ok;
  logic [4*CH-1:0] nib;
  logic [CH-1:0]   nib_stb, dec_rst, busy;
  logic            irq;

  jtdd_adpcm_seq #(.CH(CH), .AW(AW), .IRQ_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .cen_smp(cen_smp), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .nib(nib), .nib_stb(nib_stb), .dec_rst(dec_rst), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ROM contents: incrementing bytes, page and bit16 dependent, per-channel salt
  function automatic logic [7:0] romFn(input int k, input logic [AW-1:0] a);
    logic [7:0] pgd;
    logic [7:0] r;
    pgd = 8'(a[16:8] - 9'h010);
    r = 8'hA5 + a[7:0] + 8'(pgd * 8'h3B) + (a[16] ? 8'h6E : 8'h00);
    if (k == 1) r = r ^ 8'h5A;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Registered ROM: data follows the address one clk later, ok after dly stable clks
  int dly = 3;
  bit ok_always = 1'b0;
  for (genvar g = 0; g < CH; g++) begin : g_rom
    logic [AW-1:0] last_a = '0;
    logic [7:0]    dat = '0;
    int            cnt = 0;
    always @(posedge clk) begin
      dat <= romFn(g, rom_addr[g*AW +: AW]);
      if (rom_cs[g] && rom_addr[g*AW +: AW] == last_a) cnt <= cnt + 1;
      else cnt <= 0;
      last_a <= rom_addr[g*AW +: AW];
    end
    assign rom_data[g*8 +: 8] = dat;
    assign rom_ok[g] = ok_always | (rom_cs[g] && cnt >= dly);
  end

  bit cen_en = 1'b0;
  int cen_per = 16;
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (!cen_en) begin
        c = 0;
        cen_smp = 1'b0;
      end else begin
        c++;
        if (c >= cen_per) begin
          c = 0;
          cen_smp = 1'b1;
        end else begin
          cen_smp = 1'b0;
        end
      end
    end
  end

  logic [3:0]    exp_nib [CH][$];
  logic [AW-1:0] exp_addr[CH][$];
  int            nstb[CH];
  logic [7:0]    first_byte[CH];
  logic          prev_cs[CH];
  logic [AW-1:0] prev_addr[CH];
  bit            chk_en = 1'b0;

  initial begin
    for (int k = 0; k < CH; k++) begin
      nstb[k] = 0;
      prev_cs[k] = 1'b0;
      prev_addr[k] = '0;
      first_byte[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < CH; k++) begin
        if (rst_n && chk_en) begin
          if (nib_stb[k]) begin
            nstb[k]++;
            if (nstb[k] == 1) first_byte[k][7:4] = nib[k*4 +: 4];
            if (nstb[k] == 2) first_byte[k][3:0] = nib[k*4 +: 4];
            checkOutput($sformatf("stb_while_fetching ch%0d", k), 32'(prev_cs[k]), 32'd0);
            if (exp_nib[k].size() == 0)
              checkOutput($sformatf("nib_expected_left ch%0d", k), 32'd0, 32'd1);
            else
              checkOutput($sformatf("nib ch%0d #%0d", k, nstb[k]), 32'(nib[k*4 +: 4]),
                          32'(exp_nib[k].pop_front()));
          end
          if (rom_cs[k] && (!prev_cs[k] || rom_addr[k*AW +: AW] != prev_addr[k])) begin
            if (exp_addr[k].size() == 0)
              checkOutput($sformatf("addr_expected_left ch%0d", k), 32'd0, 32'd1);
            else
              checkOutput($sformatf("rom_addr ch%0d", k), 32'(rom_addr[k*AW +: AW]),
                          32'(exp_addr[k].pop_front()));
          end
        end
        prev_cs[k]   = rom_cs[k];
        prev_addr[k] = rom_addr[k*AW +: AW];
      end
    end
  end

  task automatic cpuWrite(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a;
    cpu_din  = d;
    cpu_wr   = 1'b1;
    @(negedge clk);
    cpu_wr   = 1'b0;
  endtask

  task automatic cpuRead(input logic [5:0] a, output logic [7:0] d);
    cpu_addr = a;
    #1;
    d = cpu_dout;
  endtask

  task automatic checkReg(input string name, input int k, input int r, input logic [7:0] exp);
    logic [7:0] d;
    cpuRead({3'(k), 3'(r)}, d);
    checkOutput(name, 32'(d), 32'(exp));
  endtask

  task automatic pauseCen();
    cen_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pushSample(input int k, input logic [8:0] s, input logic [8:0] e);
    logic [AW-1:0] a, last;
    logic [7:0]    b;
    bit            fin;
    a = {s, 8'h00};
    last = {e, 8'hFF};
    fin = 1'b0;
    while (!fin) begin
      exp_addr[k].push_back(a);
      b = romFn(k, a);
      exp_nib[k].push_back(b[7:4]);
      exp_nib[k].push_back(b[3:0]);
      if (a == last) fin = 1'b1;
      else a = a + 1'b1;
    end
  endtask

  // Program pages and start; returns on the negedge right after the start commits
  task automatic applyStimulus(input int k, input logic [8:0] s, input logic [8:0] e);
    pauseCen();
    cpuWrite({3'(k), 3'd0}, s[7:0]);
    cpuWrite({3'(k), 3'd1}, {7'd0, s[8]});
    cpuWrite({3'(k), 3'd2}, e[7:0]);
    cpuWrite({3'(k), 3'd3}, {7'd0, e[8]});
    exp_nib[k].delete();
    exp_addr[k].delete();
    pushSample(k, s, e);
    nstb[k] = 0;
    cpuWrite({3'(k), 3'd4}, 8'h01);
  endtask

  task automatic stopChannel(input int k);
    pauseCen();
    cpuWrite({3'(k), 3'd4}, 8'h00);
    exp_nib[k].delete();
    exp_addr[k].delete();
  endtask

  task automatic waitIdle(input int k, input int max);
    int i;
    i = 0;
    while (busy[k] && i < max) begin
      @(negedge clk);
      i++;
    end
    checkOutput($sformatf("wait_idle ch%0d", k), 32'(busy[k]), 32'd0);
  endtask

  task automatic waitStb(input int k, input int n, input int max);
    int i;
    i = 0;
    while (nstb[k] < n && i < max) begin
      @(negedge clk);
      i++;
    end
    checkOutput($sformatf("wait_stb ch%0d", k), 32'(nstb[k] >= n), 32'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset rom_cs", 32'(rom_cs), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset dec_rst", 32'(dec_rst), 32'h3);
    checkOutput("reset nib_stb", 32'(nib_stb), 32'd0);
    checkOutput("reset irq", 32'(irq), 32'd0);
    checkReg("reset start_lo ch0", 0, 0, 8'h00);
    checkReg("reset status ch1", 1, 5, 8'h00);
    checkReg("unmapped channel", 2, 0, 8'hFF);
    checkReg("reserved reg6", 0, 6, 8'hFF);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    cpuWrite({3'd1, 3'd1}, 8'hFF);
    checkReg("start_hi masked", 1, 1, 8'h01);
    cpuWrite({3'd1, 3'd1}, 8'h00);

    $display("[TB] single page playback on ch0");
    dly = 3; ok_always = 1'b0; cen_per = 16;
    applyStimulus(0, 9'h010, 9'h010);
    cen_en = 1'b1;
    waitIdle(0, 20000);
    checkOutput("t1 strobes", 32'(nstb[0]), 32'd512);
    checkOutput("t1 nibbles left", 32'(exp_nib[0].size()), 32'd0);
    checkOutput("t1 first byte", 32'(first_byte[0]), 32'hA5);
    checkReg("t1 status ch0", 0, 5, 8'h02);
    checkOutput("t1 irq", 32'(irq), 32'd1);
    checkOutput("t1 ch1 busy", 32'(busy[1]), 32'd0);
    checkReg("t1 status ch1", 1, 5, 8'h00);
    checkOutput("t1 dec_rst ch0", 32'(dec_rst[0]), 32'd1);
    cpuWrite({3'd0, 3'd4}, 8'h80);
    checkOutput("t1 irq cleared", 32'(irq), 32'd0);
    checkReg("t1 status cleared", 0, 5, 8'h00);

    $display("[TB] continuous rom_ok");
    ok_always = 1'b1; cen_per = 8;
    applyStimulus(0, 9'h020, 9'h020);
    cen_en = 1'b1;
    waitIdle(0, 20000);
    checkOutput("t2 strobes", 32'(nstb[0]), 32'd512);
    checkOutput("t2 first byte", 32'(first_byte[0]), 32'h55);
    checkReg("t2 status ch0", 0, 5, 8'h02);
    cpuWrite({3'd0, 3'd4}, 8'h80);
    ok_always = 1'b0;

    $display("[TB] underrun");
    dly = 200; cen_per = 100;
    applyStimulus(0, 9'h030, 9'h030);
    cen_en = 1'b1;
    waitStb(0, 6, 5000);
    stopChannel(0);
    checkReg("t3 status ch0", 0, 5, 8'h04);
    checkOutput("t3 first byte", 32'(first_byte[0]), 32'h05);
    cpuWrite({3'd0, 3'd4}, 8'h80);
    checkReg("t3 status cleared", 0, 5, 8'h00);

    $display("[TB] address wrap");
    dly = 1; cen_per = 8;
    applyStimulus(0, 9'h1FF, 9'h000);
    cen_en = 1'b1;
    waitIdle(0, 20000);
    checkOutput("t4 strobes", 32'(nstb[0]), 32'd1024);
    checkOutput("t4 first byte", 32'(first_byte[0]), 32'h28);
    checkReg("t4 status ch0", 0, 5, 8'h02);
    cpuWrite({3'd0, 3'd4}, 8'h80);

    $display("[TB] restart ch1, stop ch0");
    dly = 3; cen_per = 16;
    applyStimulus(0, 9'h040, 9'h041);
    applyStimulus(1, 9'h050, 9'h050);
    cen_en = 1'b1;
    waitStb(1, 20, 5000);
    applyStimulus(1, 9'h060, 9'h060);
    checkOutput("t5 dec_rst pulse", 32'(dec_rst[1]), 32'd1);
    checkOutput("t5 restart addr", 32'(rom_addr[AW +: AW]), 32'h06000);
    checkOutput("t5 restart cs", 32'(rom_cs[1]), 32'd1);
    @(negedge clk);
    checkOutput("t5 dec_rst low", 32'(dec_rst[1]), 32'd0);
    stopChannel(0);
    checkOutput("t5 stop cs", 32'(rom_cs[0]), 32'd0);
    checkOutput("t5 stop busy", 32'(busy[0]), 32'd0);
    checkReg("t5 status ch0", 0, 5, 8'h00);
    cen_en = 1'b1;
    waitIdle(1, 20000);
    checkOutput("t5 strobes ch1", 32'(nstb[1]), 32'd512);
    checkOutput("t5 first byte ch1", 32'(first_byte[1]), 32'h4F);
    checkReg("t5 status ch1", 1, 5, 8'h02);
    checkReg("t5 status ch0 after", 0, 5, 8'h00);
    checkOutput("t5 irq", 32'(irq), 32'd1);
    cpuWrite({3'd1, 3'd4}, 8'h80);

    $display("[TB] async reset during playback");
    applyStimulus(0, 9'h070, 9'h070);
    applyStimulus(1, 9'h071, 9'h071);
    cen_en = 1'b1;
    waitStb(0, 4, 3000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    chk_en = 1'b0;
    cen_en = 1'b0;
    #1;
    checkOutput("t6 rom_cs", 32'(rom_cs), 32'd0);
    checkOutput("t6 busy", 32'(busy), 32'd0);
    checkOutput("t6 dec_rst", 32'(dec_rst), 32'h3);
    for (int k = 0; k < CH; k++) begin
      exp_nib[k].delete();
      exp_addr[k].delete();
    end
    checkReg("t6 start_lo ch0", 0, 0, 8'h00);
    checkReg("t6 end_lo ch1", 1, 2, 8'h00);
    checkReg("t6 status ch0", 0, 5, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
